xor_gate_nand: RTL and testbench



---
 rtl/xor_nand_pkg.sv | 16 +
 rtl/nand2_cell.sv | 10 +
 rtl/xor_nand_cell.sv | 17 +
 rtl/xor_gate_nand.sv | 52 +++++
 tb/tb_xor_gate_nand.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/xor_nand_pkg.sv
// Shared constants and helpers for the NAND-only XOR blocks.
package xor_nand_pkg;

  localparam int XOR_NAND_MAX_WIDTH = 64;

  // Ceiling log2, usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nand2_cell.sv
// Two-input NAND primitive; the only logic operator in the XOR datapath.
module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/xor_nand_cell.sv
// One-bit XOR built from the classic four-NAND arrangement.
module xor_nand_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n1;
  logic n2;
  logic n3;

  nand2_cell u_n1 (.a(a),  .b(b),  .y(n1));
  nand2_cell u_n2 (.a(a),  .b(n1), .y(n2));
  nand2_cell u_n3 (.a(b),  .b(n1), .y(n3));
  nand2_cell u_n4 (.a(n2), .b(n3), .y(y));

endmodule

// File: rtl/xor_gate_nand.sv
// Bitwise XOR lanes plus XOR-reduction parity, all from NAND cells,
// with combinational and registered outputs.
module xor_gate_nand
  import xor_nand_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             parity
);

  localparam int TREE_DEPTH = clog2(WIDTH);

  if (WIDTH < 1 || WIDTH > XOR_NAND_MAX_WIDTH || (1 << TREE_DEPTH) < WIDTH) begin : g_bad_width
    $error("xor_gate_nand: WIDTH %0d outside 1..%0d", WIDTH, XOR_NAND_MAX_WIDTH);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    xor_nand_cell u_xor (.a(a[i]), .b(b[i]), .y(y_comb[i]));
  end

  // Heap-ordered tree: leaves at WIDTH..2*WIDTH-1, node k combines 2k and 2k+1.
  // This uses WIDTH-1 cells and has depth ceil(log2(WIDTH)) for any WIDTH.
  for (genvar k = 1; k < 2 * WIDTH; k++) begin : g_node
    logic v;
    if (k >= WIDTH) begin : g_leaf
      assign v = y_comb[k-WIDTH];
    end else begin : g_inner
      xor_nand_cell u_xor (.a(g_node[2*k].v), .b(g_node[2*k+1].v), .y(v));
    end
  end

  logic parity_comb;
  assign parity_comb = g_node[1].v;

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= '0;
      parity <= 1'b0;
    end else begin
      y      <= y_comb;
      parity <= parity_comb;
    end
  end

endmodule

// File: tb/tb_xor_gate_nand.sv
// Scoreboard bench for xor_gate_nand at WIDTH 8, 1 and 5.
module tb_xor_gate_nand;

  logic       clk;
  logic       rst_n;
  logic [7:0] a8, b8, y_comb8, y8;
  logic       p8;
  logic [0:0] a1, b1, y_comb1, y1;
  logic       p1;
  logic [4:0] a5, b5, y_comb5, y5;
  logic       p5;

  xor_gate_nand #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .y_comb(y_comb8), .y(y8), .parity(p8)
  );
  xor_gate_nand #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .y_comb(y_comb1), .y(y1), .parity(p1)
  );
  xor_gate_nand #(.WIDTH(5)) u_w5 (
    .clk(clk), .rst_n(rst_n), .a(a5), .b(b5), .y_comb(y_comb5), .y(y5), .parity(p5)
  );

  typedef struct {
    logic [7:0] y8;
    logic       p8;
    logic       y1;
    logic       p1;
    logic [4:0] y5;
    logic       p5;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic mon_en;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: XOR per lane, parity as odd population count.
  task automatic push_exp();
    exp_t e;
    e.y8 = a8 ^ b8;
    e.p8 = ($countones(a8 ^ b8) % 2) == 1;
    e.y1 = a1[0] ^ b1[0];
    e.p1 = a1[0] ^ b1[0];
    e.y5 = a5 ^ b5;
    e.p5 = ($countones(a5 ^ b5) % 2) == 1;
    q.push_back(e);
  endtask

  task automatic check_comb();
    check("y_comb8", 64'(y_comb8), 64'(a8 ^ b8));
    check("y_comb1", 64'(y_comb1), 64'(a1 ^ b1));
    check("y_comb5", 64'(y_comb5), 64'(a5 ^ b5));
  endtask

  task automatic drive(input logic [7:0] va8, input logic [7:0] vb8,
                       input logic va1, input logic vb1,
                       input logic [4:0] va5, input logic [4:0] vb5);
    @(negedge clk);
    a8 = va8; b8 = vb8; a1 = va1; b1 = vb1; a5 = va5; b5 = vb5;
    push_exp();
    #1;
    check_comb();
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && q.size() > 0) begin
      mon_e = q.pop_front();
      check("y8", 64'(y8), 64'(mon_e.y8));
      check("parity8", 64'(p8), 64'(mon_e.p8));
      check("y1", 64'(y1), 64'(mon_e.y1));
      check("parity1", 64'(p1), 64'(mon_e.p1));
      check("y5", 64'(y5), 64'(mon_e.y5));
      check("parity5", 64'(p5), 64'(mon_e.p5));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    mon_en = 1'b0;
    a8 = 8'hA5; b8 = 8'h3C; a1 = 1'b1; b1 = 1'b0; a5 = 5'h15; b5 = 5'h02;

    // Held in reset across clock edges
    repeat (2) @(posedge clk);
    #2;
    check("rst_y8", 64'(y8), 64'h0);
    check("rst_parity8", 64'(p8), 64'h0);
    check("rst_y1", 64'(y1), 64'h0);
    check("rst_parity1", 64'(p1), 64'h0);
    check("rst_y5", 64'(y5), 64'h0);
    check("rst_y_comb1", 64'(y_comb1), 64'h1);
    check("rst_y_comb8", 64'(y_comb8), 64'h99);

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push_exp();

    // Directed vectors, including WIDTH=1 exhaustive
    drive(8'hA5, 8'h3C, 1'b0, 1'b0, 5'h1F, 5'h00);
    drive(8'hFF, 8'hFE, 1'b0, 1'b1, 5'h10, 5'h01);
    drive(8'h00, 8'h00, 1'b1, 1'b0, 5'h00, 5'h00);
    drive(8'h80, 8'h00, 1'b1, 1'b1, 5'h1F, 5'h1F);
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 5'h01, 5'h00);

    for (int i = 0; i < 150; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 5'($urandom));
    end

    // Reset asserted between edges with y1 = 1
    drive(8'hF0, 8'h0F, 1'b1, 1'b0, 5'h07, 5'h00);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_y1", 64'(y1), 64'h0);
    check("mid_rst_y8", 64'(y8), 64'h0);
    check("mid_rst_parity8", 64'(p8), 64'h0);
    check("mid_rst_parity5", 64'(p5), 64'h0);
    check("mid_rst_y_comb1", 64'(y_comb1), 64'h1);
    check("mid_rst_y_comb8", 64'(y_comb8), 64'hFF);

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push_exp();

    for (int i = 0; i < 50; i++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 5'($urandom));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("queue_drain", 64'(q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
